// File: rtl/pktgen_stream_core.sv
// Packet generator datapath: launches packets from register-file config and
// streams them on an AXI4-Stream master, returning busy/count/error status.
//
// Ports:
//   ACLK, ARESETN        clock, asynchronous active-low reset
//   cfg_enable           generator enable
//   cfg_oneshot          1 = one packet per cfg_start, 0 = continuous
//   cfg_start            single-cycle start pulse (used only in IDLE)
//   cfg_len              payload beats per packet (latched at launch)
//   cfg_gap              idle cycles after each packet (latched at launch)
//   cfg_seed             first payload word (latched at launch)
//   m_axis_tdata/tvalid/tlast/tready   AXI4-Stream master
//   sts_busy             FSM not in IDLE
//   sts_pkt_cnt          packets completed since reset (wraps)
//   sts_len_err          sticky: launch attempted with cfg_len == 0
//
// Build option: define PKTGEN_SEQ_HDR_EN to prefix every packet with one
// header beat carrying the packet sequence number (sts_pkt_cnt at launch).

module pktgen_stream_core #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int GAP_WIDTH  = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  cfg_enable,
    input  logic                  cfg_oneshot,
    input  logic                  cfg_start,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    input  logic [GAP_WIDTH-1:0]  cfg_gap,
    input  logic [DATA_WIDTH-1:0] cfg_seed,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic                  sts_busy,
    output logic [31:0]           sts_pkt_cnt,
    output logic                  sts_len_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    state_e                state_q;
    logic [DATA_WIDTH-1:0] tdata_q;
    logic                  tvalid_q;
    logic                  tlast_q;
    logic                  hdr_q;
    logic [LEN_WIDTH-1:0]  rem_q;
    logic [GAP_WIDTH-1:0]  gap_q;
    logic [GAP_WIDTH-1:0]  gap_cnt_q;
    logic [DATA_WIDTH-1:0] seed_q;
    logic [31:0]           pkt_cnt_q;
    logic                  len_err_q;

    logic        beat_ok;
    logic        pkt_done;
    logic        gap_done;
    logic        cont_ok;
    logic        launch;
    logic [31:0] pkt_cnt_d;
    logic [31:0] seq_d;

    always_comb begin
        beat_ok   = tvalid_q & m_axis_tready;
        pkt_done  = (state_q == ST_SEND) & beat_ok & tlast_q;
        gap_done  = (state_q == ST_GAP) & (gap_cnt_q == GAP_WIDTH'(1));
        cont_ok   = cfg_enable & ~cfg_oneshot;
        pkt_cnt_d = pkt_cnt_q + 32'd1;
        // A packet finishing this cycle already counts toward the next
        // packet's sequence number.
        seq_d     = pkt_done ? pkt_cnt_d : pkt_cnt_q;
        // Continuous mode relaunches straight out of SEND/GAP so the next
        // packet's tvalid follows the last idle cycle with no extra bubble.
        launch    = ((state_q == ST_IDLE) & cfg_enable &
                     (~cfg_oneshot | cfg_start)) |
                    (((pkt_done & (gap_q == '0)) | gap_done) & cont_ok);
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q   <= ST_IDLE;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            hdr_q     <= 1'b0;
            rem_q     <= '0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
            seed_q    <= '0;
            pkt_cnt_q <= '0;
            len_err_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                end
                ST_SEND: begin
                    if (beat_ok) begin
                        if (tlast_q) begin
                            pkt_cnt_q <= pkt_cnt_d;
                            tvalid_q  <= 1'b0;
                            tlast_q   <= 1'b0;
                            if (gap_q != '0) begin
                                state_q   <= ST_GAP;
                                gap_cnt_q <= gap_q;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            // rem_q counts payload beats left after the
                            // current one; a header beat leaves all of them.
                            tdata_q <= hdr_q ? seed_q
                                             : tdata_q + DATA_WIDTH'(1);
                            hdr_q   <= 1'b0;
                            rem_q   <= rem_q - LEN_WIDTH'(1);
                            tlast_q <= (rem_q == LEN_WIDTH'(1));
                        end
                    end
                end
                ST_GAP: begin
                    gap_cnt_q <= gap_cnt_q - GAP_WIDTH'(1);
                    if (gap_done) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase

            if (launch) begin
                gap_q  <= cfg_gap;
                seed_q <= cfg_seed;
                if (cfg_len == '0) begin
                    len_err_q <= 1'b1;
                    state_q   <= ST_IDLE;
                    tvalid_q  <= 1'b0;
                    tlast_q   <= 1'b0;
                end else begin
                    len_err_q <= 1'b0;
                    state_q   <= ST_SEND;
                    tvalid_q  <= 1'b1;
`ifdef PKTGEN_SEQ_HDR_EN
                    tdata_q   <= DATA_WIDTH'(seq_d);
                    hdr_q     <= 1'b1;
                    tlast_q   <= 1'b0;
                    rem_q     <= cfg_len;
`else
                    tdata_q   <= cfg_seed;
                    hdr_q     <= 1'b0;
                    tlast_q   <= (cfg_len == LEN_WIDTH'(1));
                    rem_q     <= cfg_len - LEN_WIDTH'(1);
`endif
                end
            end
        end
    end

`ifndef PKTGEN_SEQ_HDR_EN
    logic unused_seq;
    assign unused_seq = ^seq_d;
`endif

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign sts_busy      = (state_q != ST_IDLE);
    assign sts_pkt_cnt   = pkt_cnt_q;
    assign sts_len_err   = len_err_q;

endmodule

// File: doc/pktgen_stream_core.md
Name: pktgen_stream_core

Overview:
- Datapath core of the Packet Generator IP. Sits directly downstream of the S00_AXI register file.
- Consumes the control/config register values the register file exposes and emits generated packets on an AXI4-Stream master.
- Returns status (busy, packet count, length error) that the register file maps back into read-only registers.

Parameters:
- DATA_WIDTH, 32, width of m_axis_tdata and cfg_seed
- LEN_WIDTH, 16, width of cfg_len (payload beats per packet)
- GAP_WIDTH, 16, width of cfg_gap (idle cycles between packets)

Ports:
- ACLK  in  1  single clock
- ARESETN  in  1  asynchronous, active-low reset
- cfg_enable  in  1  generator enable (register 0 bit 0)
- cfg_oneshot  in  1  1 = one packet per cfg_start pulse; 0 = continuous while enabled (register 0 bit 1)
- cfg_start  in  1  single-cycle start pulse (write-1 to register 0 bit 2, self-clearing in register file)
- cfg_len  in  LEN_WIDTH  payload beats per packet (register 1)
- cfg_gap  in  GAP_WIDTH  idle cycles after each packet (register 2)
- cfg_seed  in  DATA_WIDTH  first payload word (register 3)
- m_axis_tdata  out  DATA_WIDTH  stream data
- m_axis_tvalid  out  1  stream valid
- m_axis_tlast  out  1  last beat of packet
- m_axis_tready  in  1  stream ready
- sts_busy  out  1  high in any state other than IDLE
- sts_pkt_cnt  out  32  packets completed since reset, wraps at 2^32
- sts_len_err  out  1  sticky; set on a launch attempt with cfg_len==0; cleared only by reset or by a successful launch

Behaviour:
- Reset (ARESETN low, asynchronous): all outputs 0, FSM to IDLE, counters 0. Takes effect immediately mid-packet; no partial-packet completion.
- Launch condition in IDLE:
  - cfg_enable && cfg_oneshot && cfg_start, or cfg_enable && !cfg_oneshot.
  - cfg_start is ignored outside IDLE.
- At launch:
  - cfg_len, cfg_gap and cfg_seed are latched; config changes mid-packet have no effect.
  - If latched cfg_len==0: set sts_len_err, stay IDLE, emit nothing.
- FSM states and transitions:
  - IDLE -> SEND on valid launch. m_axis_tvalid rises the cycle after the launch condition is sampled (1-cycle latency).
  - SEND: beat k (k = 0 .. len-1) carries tdata = seed + k, modulo 2^DATA_WIDTH (wraps silently). tlast = 1 on k == len-1.
  - SEND -> GAP when the last beat handshakes and gap > 0.
  - SEND -> IDLE/relaunch when the last beat handshakes and gap == 0. In continuous mode the next packet's tvalid starts the cycle after tlast handshake.
  - GAP: down-counter loaded with gap; tvalid = 0 for exactly gap cycles, then IDLE.
- Handshake rules:
  - Beat accepted when tvalid && tready.
  - tdata/tlast held stable while tvalid && !tready.
  - tvalid is never withdrawn before acceptance.
  - Beat rate: 1 beat/cycle with tready held high.
- sts_pkt_cnt increments on the cycle the tlast beat handshakes.
- cfg_enable deasserted mid-SEND: current packet completes in full, then GAP/IDLE; no further launch.
- cfg_enable deasserted in GAP: the gap still runs out.
- Each packet restarts at the seed latched at its own launch.
- cfg_len == 1: a single beat with tlast = 1.

Optional Feature:
- Macro: PKTGEN_SEQ_HDR_EN.
- Defined:
  - Each packet is prefixed with one header beat: tdata = {sequence number, zero-extended to DATA_WIDTH}, tlast = 0.
  - Sequence number = sts_pkt_cnt value at launch.
  - Packet length becomes len + 1 beats.
  - Payload numbering (seed + k) is unchanged.
- Not defined: no header beat; packet is exactly len beats.
- All other timing is identical in both builds.

Test Plan:
- Oneshot: enable=1, oneshot=1, len=4, gap=0, seed=0x00000001, start pulse, tready=1 -> beats 1, 2, 3, 4 on consecutive cycles; tlast on 4th; tvalid rises 1 cycle after start; sts_pkt_cnt=1; sts_busy low afterwards.
- Backpressure: len=3, seed=0x10, tready toggling 1,0,0,1,0,1 -> exactly beats 0x10, 0x11, 0x12 accepted; data/tlast stable through stalls; no duplicate or missing beat.
- Continuous with gap: oneshot=0, len=2, gap=3 for 3 packets -> each pair of beats followed by exactly 3 tvalid-low cycles; sts_pkt_cnt=3; deassert enable mid-packet -> that packet completes, then tvalid stays 0.
- Wrap and errors: seed=0xFFFFFFFE, len=4 -> data 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000001. Then len=0 + start -> no beats, sts_len_err=1. Then len=1 + start -> single beat with tlast, sts_len_err=0.
- Reset mid-packet: assert ARESETN low during beat 2 of len=8 -> tvalid, tlast, sts_busy, sts_pkt_cnt immediately 0. After release, a new start produces a fresh packet from beat 0.
- With PKTGEN_SEQ_HDR_EN: two oneshot packets, len=2, seed=0x5 -> beats 0x0, 0x5, 0x6(last), then 0x1, 0x5, 0x6(last).
